// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding and data-memory handshake control for a 3-stage pipeline
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             ex_read_en,
  input  logic             ex_write_en,
  input  logic             ex_br_taken,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_ex_en,
  output logic             if_ex_flush,
  output logic             ex_wb_flush,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, MEM_WAIT, ERR} state_t;
  state_t state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic mem_op, go, idle, wait_st;
  assign mem_op = ex_read_en | ex_write_en;
  assign idle = state == IDLE;
  assign wait_st = state == MEM_WAIT;
  // go: the pipeline advances this cycle (no access, zero-wait access, or access completing)
  assign go = (idle & (~mem_op | dmem_ack)) | (wait_st & dmem_ack);
  // pipeline controls, forwarding and next-state/wait-counter logic
  always_comb begin
    pc_en = ~rst & go;
    if_ex_en = ~rst & go;
    dmem_req = ~rst & ((idle & mem_op) | wait_st);
    ex_wb_flush = rst | ~go;
    if_ex_flush = rst | state == ERR | (idle & ~mem_op & ex_br_taken);
    fwd_a = ~rst & wb_reg_write & |wb_rd & (wb_rd == ex_rs1);
    fwd_b = ~rst & wb_reg_write & |wb_rd & (wb_rd == ex_rs2);
    state_n = state;
    wcnt_n = wcnt;
    if (idle && mem_op && !dmem_ack) begin
      state_n = MEM_WAIT;
      wcnt_n = WW'(1);
    end else if (wait_st) begin
      state_n = dmem_ack ? IDLE : (wcnt == WW'(MEM_TIMEOUT) ? ERR : MEM_WAIT);
      wcnt_n = dmem_ack ? '0 : (wcnt == WW'(MEM_TIMEOUT) ? wcnt : wcnt + 1'b1);
    end
  end
  // state, wait counter, sticky error flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt <= '0;
      mem_err <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      wcnt <= wcnt_n;
      mem_err <= mem_err | (state_n == ERR);
      if (!pc_en && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of forwarding, stalls, timeout trap and counter saturation
module tb_pipe_hazard_ctrl;
  logic clk = 0;
  logic rst, ex_read_en, ex_write_en, ex_br_taken, wb_reg_write, dmem_ack;
  logic [4:0] ex_rs1, ex_rs2, wb_rd;
  logic pc_en, if_ex_en, if_ex_flush, ex_wb_flush, fwd_a, fwd_b, dmem_req, mem_err;
  logic [2:0] stall_cnt;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_read_en(ex_read_en), .ex_write_en(ex_write_en), .ex_br_taken(ex_br_taken),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .if_ex_en(if_ex_en), .if_ex_flush(if_ex_flush), .ex_wb_flush(ex_wb_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_req(dmem_req), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic stall_chk(input string tag);
    chk({tag, "_req"}, dmem_req, 1);
    chk({tag, "_pc"}, pc_en, 0);
    chk({tag, "_ifen"}, if_ex_en, 0);
    chk({tag, "_exwb"}, ex_wb_flush, 1);
    chk({tag, "_ifx"}, if_ex_flush, 0);
  endtask
  initial begin
    rst = 1; ex_read_en = 0; ex_write_en = 0; ex_br_taken = 0; dmem_ack = 0;
    wb_reg_write = 1; wb_rd = 5; ex_rs1 = 5; ex_rs2 = 5;
    #2;
    chk("rst_pc", pc_en, 0);
    chk("rst_ifen", if_ex_en, 0);
    chk("rst_ifx", if_ex_flush, 1);
    chk("rst_exwb", ex_wb_flush, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_fwda", fwd_a, 0);
    cyc(); cyc();
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_err", mem_err, 0);
    rst = 0;
    #1;
    chk("fwd_a", fwd_a, 1);
    chk("fwd_b", fwd_b, 1);
    chk("idle_pc", pc_en, 1);
    chk("idle_exwb", ex_wb_flush, 0);
    ex_rs2 = 6; #1;
    chk("fwd_b_miss", fwd_b, 0);
    wb_rd = 0; ex_rs1 = 0; #1;
    chk("fwd_x0", fwd_a, 0);
    wb_rd = 5; ex_rs1 = 5; wb_reg_write = 0; #1;
    chk("fwd_nowr", fwd_a, 0);
    cyc();
    ex_br_taken = 1; #1;
    chk("br_ifx", if_ex_flush, 1);
    chk("br_pc", pc_en, 1);
    cyc();
    ex_br_taken = 0; #1;
    chk("br_ifx_off", if_ex_flush, 0);
    chk("br_cnt", stall_cnt, 0);
    ex_read_en = 1; ex_br_taken = 1; #1;
    stall_chk("ld0");
    cyc();
    ex_br_taken = 0;
    stall_chk("ld1");
    cyc();
    stall_chk("ld2");
    cyc();
    dmem_ack = 1; #1;
    chk("ld_ack_req", dmem_req, 1);
    chk("ld_ack_pc", pc_en, 1);
    chk("ld_ack_exwb", ex_wb_flush, 0);
    cyc();
    ex_read_en = 0; dmem_ack = 0; #1;
    chk("ld_cnt", stall_cnt, 3);
    chk("ld_idle_req", dmem_req, 0);
    chk("ld_idle_pc", pc_en, 1);
    rst = 1; cyc(); rst = 0;
    ex_write_en = 1; dmem_ack = 1; #1;
    chk("st_req", dmem_req, 1);
    chk("st_pc", pc_en, 1);
    chk("st_exwb", ex_wb_flush, 0);
    cyc();
    ex_write_en = 0; #1;
    chk("stray_ack_req", dmem_req, 0);
    chk("stray_ack_pc", pc_en, 1);
    cyc();
    dmem_ack = 0; #1;
    chk("st_cnt", stall_cnt, 0);
    ex_read_en = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      stall_chk($sformatf("to%0d", i));
      chk($sformatf("to%0d_err", i), mem_err, 0);
      cyc();
    end
    chk("err_flag", mem_err, 1);
    chk("err_req", dmem_req, 0);
    chk("err_pc", pc_en, 0);
    chk("err_ifx", if_ex_flush, 1);
    chk("err_exwb", ex_wb_flush, 1);
    chk("err_cnt5", stall_cnt, 5);
    dmem_ack = 1; cyc();
    chk("err_ack_flag", mem_err, 1);
    chk("err_ack_req", dmem_req, 0);
    chk("err_ack_pc", pc_en, 0);
    chk("err_cnt6", stall_cnt, 6);
    cyc(); cyc(); cyc(); cyc(); cyc();
    chk("sat_cnt", stall_cnt, 7);
    dmem_ack = 0; rst = 1; cyc();
    rst = 0; ex_read_en = 0; #1;
    chk("clr_err", mem_err, 0);
    chk("clr_cnt", stall_cnt, 0);
    chk("clr_pc", pc_en, 1);
    ex_read_en = 1; cyc(); cyc();
    stall_chk("abort_wait");
    rst = 1; #1;
    chk("abort_req_rst", dmem_req, 0);
    cyc();
    rst = 0; ex_read_en = 0; #1;
    chk("abort_idle_req", dmem_req, 0);
    chk("abort_idle_pc", pc_en, 1);
    chk("abort_cnt", stall_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
